// File: rtl/sar_pkg.sv
// Shared SAR ADC definitions: default resolution, logic level constants and the result word type.
package sar_pkg;

   localparam int unsigned BIT_ADC_DEFAULT = 6;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

   typedef logic [BIT_ADC_DEFAULT-1:0] adc_word_t;

endpackage

// File: rtl/sar_result_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible on rd_data whenever not empty.
module sar_result_fifo #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra MSB so full and empty are distinguishable at equal indices.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign rd_data = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/sar_result_reader.sv
// Captures SAR conversion results on EOC rising edge and streams them out through a FWFT FIFO.
// Define SAR_AVG_EN to push the truncated mean of every 2**AVG_LOG2 captures instead of each one.
module sar_result_reader
   import sar_pkg::*;
#(
   parameter int unsigned BIT_ADC    = BIT_ADC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned AVG_LOG2   = 2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          EOC,
   input  logic [BIT_ADC-1:0]            DIGITAL_OUT,
   input  logic                          ENABLE,
   output logic [BIT_ADC-1:0]            DATA,
   output logic                          VALID,
   input  logic                          READY,
   output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
   output logic                          OVF,
   input  logic                          OVF_CLR
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (AVG_LOG2 > 16) begin : g_bad_avg
      $error("AVG_LOG2 out of range");
   end

   logic               eoc_q;
   logic               cap;
   logic               push_req;
   logic [BIT_ADC-1:0] push_word;
   logic               pop;
   logic               drop;
   logic               fifo_empty;
   logic               fifo_full;
   logic [BIT_ADC-1:0] fifo_rd;
   logic [BIT_ADC-1:0] hold_q;
   logic               ovf_q;

   assign cap = EOC & ~eoc_q & ENABLE;

`ifdef SAR_AVG_EN
   localparam int unsigned ACC_W = BIT_ADC + AVG_LOG2;
   localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] cnt_q;
   logic             last;

   // ACC_W bits hold 2**AVG_LOG2 full-scale samples without overflow.
   assign acc_sum   = acc_q + ACC_W'(DIGITAL_OUT);
   assign last      = (cnt_q == CNT_W'((1 << AVG_LOG2) - 1));
   assign push_req  = cap & last;
   assign push_word = BIT_ADC'(acc_sum >> AVG_LOG2);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (!ENABLE) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (cap) begin
         if (last) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
`else
   assign push_req  = cap;
   assign push_word = DIGITAL_OUT;
`endif

   assign pop  = ~fifo_empty & READY;
   assign drop = push_req & fifo_full & ~pop;

   sar_result_fifo #(
      .WIDTH (BIT_ADC),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push_req),
      .push_data (push_word),
      .pop       (pop),
      .rd_data   (fifo_rd),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .level     (LEVEL)
   );

   // hold_q keeps the last consumed word so DATA stays put once the FIFO drains.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         eoc_q  <= LOW;
         hold_q <= '0;
         ovf_q  <= LOW;
      end else begin
         eoc_q <= EOC;
         if (pop) hold_q <= fifo_rd;
         if (drop) ovf_q <= HIGH;
         else if (OVF_CLR) ovf_q <= LOW;
      end
   end

   assign VALID = ~fifo_empty;
   assign DATA  = fifo_empty ? hold_q : fifo_rd;
   assign OVF   = ovf_q;

endmodule

// File: tb/tb_sar_result_reader.sv
// Scoreboard bench for sar_result_reader; expected words are queued at capture and checked on pop.
module tb_sar_result_reader;
   import sar_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = 4;
`ifdef SAR_AVG_EN
   localparam int L   = 2;
   localparam int SPE = 4;
`else
   localparam int SPE = 1;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EOC = 1'b0;
   logic       ENABLE = 1'b0;
   logic       READY = 1'b0;
   logic       OVF_CLR = 1'b0;
   adc_word_t  DIGITAL_OUT = '0;
   adc_word_t  DATA;
   logic       VALID;
   logic       OVF;
   logic [LW-1:0] LEVEL;

   int        vectors = 0;
   int        miscompares = 0;
   int        n_pop = 0;
   adc_word_t last_pop = '0;
   adc_word_t exp_q[$];
   int        m_acc = 0;
   int        m_cnt = 0;

   sar_result_reader #(
      .BIT_ADC    (6),
      .FIFO_DEPTH (DEPTH),
      .AVG_LOG2   (2)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .EOC         (EOC),
      .DIGITAL_OUT (DIGITAL_OUT),
      .ENABLE      (ENABLE),
      .DATA        (DATA),
      .VALID       (VALID),
      .READY       (READY),
      .LEVEL       (LEVEL),
      .OVF         (OVF),
      .OVF_CLR     (OVF_CLR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Scoreboard: occupancy tracked every cycle, head word checked whenever a pop will occur.
   always @(negedge CLK) begin
      if (!RST) begin
         vectors++;
         if (LEVEL !== LW'(exp_q.size())) begin
            miscompares++;
            $display("FAIL level_track: LEVEL=%0d, required %0d", LEVEL, exp_q.size());
         end
         if (VALID && READY) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL pop_unexpected: DATA=%h, required no VALID", DATA);
            end else begin
               adc_word_t e;
               e = exp_q.pop_front();
               if (DATA !== e) begin
                  miscompares++;
                  $display("FAIL pop_data: DATA=%h, required %h", DATA, e);
               end
               n_pop++;
               last_pop = DATA;
            end
         end
      end
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // One conversion: EOC high for len cycles; the expected push is decided after the monitor's pop.
   task automatic conv(input adc_word_t v, input int len, input bit pulse_rdy);
      adc_word_t w;
      bit        do_push;
      tick;
      EOC = 1'b1;
      DIGITAL_OUT = v;
      if (pulse_rdy) READY = 1'b1;
      @(negedge CLK);
      #1;
      do_push = 1'b0;
      w = v;
      if (ENABLE) begin
`ifdef SAR_AVG_EN
         if (m_cnt == SPE - 1) begin
            w = adc_word_t'((m_acc + int'(v)) >> L);
            m_acc = 0;
            m_cnt = 0;
            do_push = 1'b1;
         end else begin
            m_acc += int'(v);
            m_cnt++;
         end
`else
         do_push = 1'b1;
`endif
      end
      if (do_push && exp_q.size() < DEPTH) exp_q.push_back(w);
      repeat (len) tick;
      EOC = 1'b0;
      if (pulse_rdy) READY = 1'b0;
   endtask

   task automatic drain(input string name);
      READY = 1'b1;
      for (int i = 0; i < 40 && VALID; i++) tick;
      vectors++;
      if (VALID !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drain: VALID=%b left=%0d, required VALID=0 left=0", name, VALID,
                  exp_q.size());
      end
      READY = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      vectors += 4;
      if (VALID !== 1'b0) begin miscompares++; $display("FAIL rst_valid: %b, required 0", VALID); end
      if (LEVEL !== 4'd0) begin miscompares++; $display("FAIL rst_level: %0d, required 0", LEVEL); end
      if (OVF !== 1'b0)   begin miscompares++; $display("FAIL rst_ovf: %b, required 0", OVF); end
      if (DATA !== 6'h00) begin miscompares++; $display("FAIL rst_data: %h, required 00", DATA); end
      tick;
      tick;
      RST = 1'b0;
      ENABLE = 1'b1;
      tick;
   endtask

   task automatic test_single;
      READY = 1'b1;
      conv(6'h2A, 1, 1'b0);
      vectors += 2;
      if (VALID !== 1'b1) begin miscompares++; $display("FAIL single_valid: %b, required 1", VALID); end
      if (DATA !== 6'h2A) begin miscompares++; $display("FAIL single_data: %h, required 2a", DATA); end
      tick;
      vectors += 2;
      if (VALID !== 1'b0) begin miscompares++; $display("FAIL single_clear: %b, required 0", VALID); end
      if (DATA !== 6'h2A) begin miscompares++; $display("FAIL single_hold: %h, required 2a", DATA); end
      READY = 1'b0;
   endtask

   task automatic test_long_eoc;
      READY = 1'b0;
      conv(6'h15, 3, 1'b0);
      tick;
      vectors++;
      if (LEVEL !== 4'd1) begin miscompares++; $display("FAIL long_eoc_level: %0d, required 1", LEVEL); end
      drain("long_eoc");
   endtask

   task automatic test_enable_low;
      READY = 1'b0;
      ENABLE = 1'b0;
      conv(6'h33, 1, 1'b0);
      tick;
      vectors++;
      if (LEVEL !== 4'd0) begin miscompares++; $display("FAIL enable_low: LEVEL=%0d, required 0", LEVEL); end
      ENABLE = 1'b1;
   endtask

   task automatic test_overflow;
      int n0;
      READY = 1'b0;
      for (int i = 1; i <= 9; i++) conv(adc_word_t'(i), 1, 1'b0);
      vectors += 2;
      if (LEVEL !== 4'd8) begin miscompares++; $display("FAIL ovf_level: %0d, required 8", LEVEL); end
      if (OVF !== 1'b1)   begin miscompares++; $display("FAIL ovf_set: %b, required 1", OVF); end
      OVF_CLR = 1'b1;
      tick;
      OVF_CLR = 1'b0;
      vectors++;
      if (OVF !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: %b, required 0", OVF); end
      // Set wins over a simultaneous clear.
      OVF_CLR = 1'b1;
      conv(6'h0A, 1, 1'b0);
      OVF_CLR = 1'b0;
      vectors++;
      if (OVF !== 1'b1) begin miscompares++; $display("FAIL ovf_prio: %b, required 1", OVF); end
      n0 = n_pop;
      drain("ovf");
      vectors += 3;
      if (n_pop - n0 != 8) begin miscompares++; $display("FAIL ovf_count: %0d, required 8", n_pop - n0); end
      if (last_pop !== 6'h08) begin miscompares++; $display("FAIL ovf_last: %h, required 08", last_pop); end
      if (OVF !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: %b, required 1", OVF); end
      OVF_CLR = 1'b1;
      tick;
      OVF_CLR = 1'b0;
      vectors++;
      if (OVF !== 1'b0) begin miscompares++; $display("FAIL ovf_clr2: %b, required 0", OVF); end
   endtask

   task automatic test_full_push_pop;
      READY = 1'b0;
      for (int i = 0; i < 8; i++) conv(adc_word_t'(6'h20 + i), 1, 1'b0);
      vectors++;
      if (LEVEL !== 4'd8) begin miscompares++; $display("FAIL fpp_fill: %0d, required 8", LEVEL); end
      conv(6'h3F, 1, 1'b1);
      vectors += 2;
      if (LEVEL !== 4'd8) begin miscompares++; $display("FAIL fpp_level: %0d, required 8", LEVEL); end
      if (OVF !== 1'b0)   begin miscompares++; $display("FAIL fpp_ovf: %b, required 0", OVF); end
      drain("fpp");
      vectors++;
      if (last_pop !== 6'h3F) begin miscompares++; $display("FAIL fpp_last: %h, required 3f", last_pop); end
   endtask

   task automatic test_back_to_back;
      READY = 1'b1;
      for (int i = 0; i < 6 * SPE; i++) conv(adc_word_t'($urandom), 1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         READY = 1'($urandom_range(0, 1));
         conv(adc_word_t'($urandom), $urandom_range(1, 3), 1'b0);
      end
      drain("b2b");
      OVF_CLR = 1'b1;
      tick;
      OVF_CLR = 1'b0;
   endtask

`ifdef SAR_AVG_EN
   task automatic test_avg;
      READY = 1'b0;
      conv(6'd10, 1, 1'b0);
      conv(6'd11, 1, 1'b0);
      conv(6'd12, 1, 1'b0);
      conv(6'd13, 1, 1'b0);
      tick;
      vectors += 2;
      if (LEVEL !== 4'd1) begin miscompares++; $display("FAIL avg_level: %0d, required 1", LEVEL); end
      if (DATA !== 6'd11) begin miscompares++; $display("FAIL avg_data: %0d, required 11", DATA); end
      conv(6'd20, 1, 1'b0);
      conv(6'd30, 1, 1'b0);
      ENABLE = 1'b0;
      m_acc = 0;
      m_cnt = 0;
      tick;
      ENABLE = 1'b1;
      tick;
      vectors++;
      if (LEVEL !== 4'd1) begin miscompares++; $display("FAIL avg_abort: %0d, required 1", LEVEL); end
      conv(6'd4, 1, 1'b0);
      conv(6'd5, 1, 1'b0);
      conv(6'd6, 1, 1'b0);
      conv(6'd8, 1, 1'b0);
      tick;
      vectors++;
      if (LEVEL !== 4'd2) begin miscompares++; $display("FAIL avg_fresh: %0d, required 2", LEVEL); end
      drain("avg");
      vectors++;
      if (last_pop !== 6'd5) begin miscompares++; $display("FAIL avg_last: %0d, required 5", last_pop); end
   endtask
`endif

   task automatic test_mid_reset;
      ENABLE = 1'b0;
      m_acc = 0;
      m_cnt = 0;
      tick;
      ENABLE = 1'b1;
      READY = 1'b0;
      for (int i = 0; i < 3 * SPE; i++) conv(adc_word_t'($urandom), 1, 1'b0);
      tick;
      vectors++;
      if (LEVEL !== 4'd3) begin miscompares++; $display("FAIL mid_fill: %0d, required 3", LEVEL); end
      #2;
      RST = 1'b1;
      #1;
      vectors += 3;
      if (VALID !== 1'b0) begin miscompares++; $display("FAIL mid_valid: %b, required 0", VALID); end
      if (LEVEL !== 4'd0) begin miscompares++; $display("FAIL mid_level: %0d, required 0", LEVEL); end
      if (OVF !== 1'b0)   begin miscompares++; $display("FAIL mid_ovf: %b, required 0", OVF); end
      exp_q.delete();
      m_acc = 0;
      m_cnt = 0;
      tick;
      RST = 1'b0;
      tick;
      tick;
      vectors++;
      if (VALID !== 1'b0) begin miscompares++; $display("FAIL mid_release: %b, required 0", VALID); end
   endtask

   initial begin
      test_reset;
`ifdef SAR_AVG_EN
      test_avg;
`else
      test_single;
      test_long_eoc;
      test_enable_low;
      test_overflow;
      test_full_push_pop;
`endif
      test_back_to_back;
      test_mid_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
